// File: rtl/pattern_pkg.sv
// Shared state encoding and the "01" detector step used by every channel context.
package pattern_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } pat_state_t;

    // Moore step; S2 means "01" was just completed. The unused code 2'b11 recovers to S0.
    function automatic pat_state_t pat_next(pat_state_t s, logic a);
        case (s)
            S0:      pat_next = a ? S0 : S1;
            S1:      pat_next = a ? S2 : S1;
            S2:      pat_next = a ? S0 : S1;
            default: pat_next = S0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner, one-hot.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        // Walk ptr+1 .. ptr+N so the previous winner is considered last.
        for (int k = 1; k <= int'(N); k++) begin
            cand = IW'((int'(ptr_q) + k) % int'(N));
            if (en && req[cand] && !gnt_valid) begin
                gnt_valid  = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pattern_detect_sched.sv
// One shared "01" detector time-multiplexed over N_CH serial channels, with per-channel
// context, saturating hit counters and a registered per-accept result.
module pattern_detect_sched
    import pattern_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [N_CH-1:0]         req_valid,
    input  logic [N_CH-1:0]         req_bit,
    output logic [N_CH-1:0]         req_ready,
    input  logic [N_CH-1:0]         ch_clr,
    output logic                    det_valid,
    output logic [$clog2(N_CH)-1:0] det_ch,
    output logic                    det_hit,
    input  logic [$clog2(N_CH)-1:0] rd_ch,
    output logic [CNT_W-1:0]        rd_cnt
);

    localparam int unsigned CH_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] gnt;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_valid;

    pat_state_t      ctx_q [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];

    pat_state_t      step_state;
    logic            step_hit;

    // A clearing channel is held off so the clear wins and its bit stays pending.
    assign eligible = req_valid & ~ch_clr;

    rr_arbiter #(
        .N  (N_CH),
        .IW (CH_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (eligible),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign req_ready = gnt;

    always_comb begin
        step_state = pat_next(ctx_q[gnt_idx], req_bit[gnt_idx]);
        step_hit   = gnt_valid && (step_state == S2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                ctx_q[i] <= S0;
                cnt_q[i] <= '0;
            end
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_hit   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (ch_clr[i]) begin
                    ctx_q[i] <= S0;
                    cnt_q[i] <= '0;
                end else if (gnt[i]) begin
                    ctx_q[i] <= step_state;
                    if (step_hit && (cnt_q[i] != CntMax)) begin
                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    end
                end
            end
            det_valid <= gnt_valid;
            det_ch    <= gnt_idx;
            det_hit   <= step_hit;
        end
    end

    assign rd_cnt = cnt_q[rd_ch];

endmodule

// File: tb/tb_pattern_detect_sched.sv
// Bench for pattern_detect_sched: directed scenarios plus a randomized phase against a
// last-bit-per-channel reference model.
module tb_pattern_detect_sched;

    localparam int N    = 4;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req_valid, req_bit, req_ready, ch_clr;
    logic       det_valid, det_hit;
    logic [1:0] det_ch, rd_ch;
    logic [7:0] rd_cnt;

    int total = 0;
    int bad   = 0;

    // Reference: a hit is a 1 arriving right after an accepted 0 on the same channel.
    bit last_v [N];
    bit last_b [N];
    int mcnt   [N];
    int mptr;
    int last_g;
    bit pend_v [N];
    bit pend_b [N];

    pattern_detect_sched #(
        .N_CH  (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .ch_clr    (ch_clr),
        .det_valid (det_valid),
        .det_ch    (det_ch),
        .det_hit   (det_hit),
        .rd_ch     (rd_ch),
        .rd_cnt    (rd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            last_v[i] = 1'b0;
            last_b[i] = 1'b0;
            mcnt[i]   = 0;
        end
        mptr = N - 1;
    endtask

    task automatic drive(logic [3:0] v, logic [3:0] b, logic [3:0] c);
        req_valid = v;
        req_bit   = b;
        ch_clr    = c;
    endtask

    // One clock: check the grant, clock it, then check result and selected counter.
    task automatic step();
        int         g;
        int         idx;
        bit         eh;
        bit         bv;
        logic [3:0] er;
        #1;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (mptr + k) % N;
            if (g < 0 && en && req_valid[idx] && !ch_clr[idx]) g = idx;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        eh = (g >= 0) && last_v[g] && !last_b[g] && req_bit[g];
        bv = (g >= 0) ? req_bit[g] : 1'b0;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (ch_clr[i]) begin
                last_v[i] = 1'b0;
                mcnt[i]   = 0;
            end
        end
        if (g >= 0) begin
            last_v[g] = 1'b1;
            last_b[g] = bv;
            if (eh && mcnt[g] < CMAX) mcnt[g]++;
            mptr = g;
        end
        last_g = g;
        #1;
        chk("det_valid", 32'(det_valid), 32'(g >= 0));
        if (g >= 0) begin
            chk("det_ch", 32'(det_ch), 32'(g));
            chk("det_hit", 32'(det_hit), 32'(eh));
        end
        chk("rd_cnt", 32'(rd_cnt), 32'(mcnt[rd_ch]));
    endtask

    initial begin
        logic [5:0] seq_bits;
        logic [5:0] seq_hits;

        reset = 1'b1;
        en    = 1'b0;
        rd_ch = '0;
        drive(4'h0, 4'h0, 4'h0);
        model_reset();
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_b[i] = 1'b0;
        end
        #12;
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        chk("rst_det_ch", 32'(det_ch), 32'd0);
        chk("rst_det_hit", 32'(det_hit), 32'd0);
        for (int r = 0; r < N; r++) begin
            rd_ch = 2'(r);
            #1;
            chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        rd_ch = 2'd0;

        // ch0 alone: 1,0,1,1,0,1 -> hits on 3rd and 6th
        seq_bits = 6'b101101;
        seq_hits = 6'b100100;
        for (int j = 0; j < 6; j++) begin
            drive(4'b0001, {3'b000, seq_bits[j]}, 4'h0);
            step();
            chk("seq_hit", 32'(det_hit), 32'(seq_hits[j]));
        end
        chk("seq_cnt0", 32'(rd_cnt), 32'd2);

        // Interleaved channels keep independent contexts
        drive(4'b0001, 4'b0000, 4'h0);
        step();
        chk("ilv_hit0a", 32'(det_hit), 32'd0);
        drive(4'b0010, 4'b0010, 4'h0);
        step();
        chk("ilv_hit1", 32'(det_hit), 32'd0);
        drive(4'b0001, 4'b0001, 4'h0);
        step();
        chk("ilv_hit0b", 32'(det_hit), 32'd1);

        // Async reset after an accept: result vanishes at once, counters clear
        drive(4'b0001, 4'b0000, 4'h0);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_det_valid", 32'(det_valid), 32'd0);
        for (int r = 0; r < N; r++) begin
            rd_ch = 2'(r);
            #1;
            chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // All channels requesting: grants rotate 0,1,2,3,0,1
        for (int j = 0; j < 6; j++) begin
            drive(4'hf, 4'b0101, 4'h0);
            step();
            chk("rr_grant", 32'(last_g), 32'(j % N));
        end

        // Clear while ch2 sits in S1: masked, context reset, later 1 is no hit
        rd_ch = 2'd2;
        drive(4'b0100, 4'b0000, 4'h0);
        step();
        drive(4'b0100, 4'b0100, 4'b0100);
        step();
        chk("clr_no_grant", 32'(last_g == 2), 32'd0);
        chk("clr_cnt2", 32'(rd_cnt), 32'd0);
        drive(4'b0100, 4'b0100, 4'h0);
        step();
        chk("clr_after_hit", 32'(det_hit), 32'd0);

        // Disabled: no grants, no results
        en = 1'b0;
        drive(4'hf, 4'h0, 4'h0);
        step();
        chk("en0_det_valid", 32'(det_valid), 32'd0);
        en = 1'b1;

        // 300 "01" pairs on ch1 saturate at 255
        rd_ch = 2'd1;
        for (int j = 0; j < 300; j++) begin
            drive(4'b0010, 4'b0000, 4'h0);
            step();
            drive(4'b0010, 4'b0010, 4'h0);
            step();
        end
        chk("sat_cnt1", 32'(rd_cnt), 32'd255);

        // Randomized traffic; requesters hold their bit until granted
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && ($urandom % 2 == 0)) begin
                    pend_v[i] = 1'b1;
                    pend_b[i] = 1'($urandom % 2);
                end
                req_valid[i] = pend_v[i];
                req_bit[i]   = pend_b[i];
                ch_clr[i]    = ($urandom % 12 == 0);
            end
            en    = ($urandom % 8 != 0);
            rd_ch = 2'($urandom % 4);
            step();
            if (last_g >= 0) pend_v[last_g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
